uart_cmd_dispatch: RTL and testbench

Command dispatcher between the shared UART receiver/transmitter and up to N command handlers (byte-reply engines such as the counter-reply handler). It decodes an opcode byte from RX and runs the selected handler through its activate/done handshake. While the handler runs, the dispatcher owns the shared UART TX port on its behalf. Unknown opcodes get a NAK byte, and a watchdog aborts handlers that never finish.

---
 rtl/uart_cmd_dispatch.sv | 127 ++++++++++++
 tb/tb_uart_cmd_dispatch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_dispatch.sv
// rtl/uart_cmd_dispatch.sv - opcode dispatcher that runs byte-reply handlers and owns the shared UART TX
module uart_cmd_dispatch #(
    parameter int         N_HANDLERS     = 4,
    parameter logic [7:0] OPCODE_BASE    = 8'h01,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    tx_active,
    input  logic                    tx_done,
    output logic [7:0]              uart_tx_data,
    output logic                    uart_tx_start,
    output logic [N_HANDLERS-1:0]   h_activate,
    input  logic [N_HANDLERS-1:0]   h_done,
    input  logic [8*N_HANDLERS-1:0] h_tx_data,
    input  logic [N_HANDLERS-1:0]   h_tx_start,
    output logic                    busy,
    output logic [7:0]              nak_count,
    output logic [7:0]              timeout_count
);

    localparam int            SW    = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;
    localparam int            WW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] TLAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    NH8   = 8'(N_HANDLERS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_RELEASE,
        S_NAK_WAIT,
        S_NAK_SEND
    } state_t;

    state_t                  state_q;
    logic [SW-1:0]           sel_q;
    logic [WW-1:0]           wdog_q;
    logic                    rx_prev_q;
    logic [N_HANDLERS-1:0]   act_q;
    logic [7:0]              data_q;
    logic                    nak_start_q;
    logic [7:0]              nak_cnt_q;
    logic [7:0]              tout_cnt_q;

    logic                    new_byte;
    logic [7:0]              op_diff;
    logic                    op_hit;
    logic                    own_tx;
    logic                    unused_tx_done;

    // tx_done is consumed by the handlers directly; the dispatcher only needs tx_active
    assign unused_tx_done = tx_done;

    assign new_byte = rx_ready && !rx_prev_q;
    assign op_diff  = rx_data - OPCODE_BASE;
    assign op_hit   = (rx_data >= OPCODE_BASE) && (op_diff < NH8);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            wdog_q      <= '0;
            rx_prev_q   <= 1'b1;
            act_q       <= '0;
            data_q      <= '0;
            nak_start_q <= 1'b0;
            nak_cnt_q   <= '0;
            tout_cnt_q  <= '0;
        end else begin
            rx_prev_q   <= rx_ready;
            nak_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (new_byte) begin
                        if (op_hit) begin
                            sel_q   <= op_diff[SW-1:0];
                            act_q   <= N_HANDLERS'(1) << op_diff[SW-1:0];
                            wdog_q  <= '0;
                            state_q <= S_ACTIVE;
                        end else begin
                            if (nak_cnt_q != 8'hFF) nak_cnt_q <= nak_cnt_q + 8'd1;
                            state_q <= S_NAK_WAIT;
                        end
                    end
                end
                S_ACTIVE: begin
                    // done has priority over an expiring watchdog on the same cycle
                    if (h_done[sel_q]) begin
                        act_q   <= '0;
                        state_q <= S_RELEASE;
                    end else if (wdog_q == TLAST) begin
                        act_q   <= '0;
                        if (tout_cnt_q != 8'hFF) tout_cnt_q <= tout_cnt_q + 8'd1;
                        state_q <= S_RELEASE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!h_done[sel_q] && !tx_active) state_q <= S_IDLE;
                end
                S_NAK_WAIT: begin
                    if (!tx_active) begin
                        data_q      <= NAK_BYTE;
                        nak_start_q <= 1'b1;
                        state_q     <= S_NAK_SEND;
                    end
                end
                S_NAK_SEND: state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // TX stays with the handler through RELEASE so its last byte can drain
    assign own_tx        = (state_q == S_ACTIVE) || (state_q == S_RELEASE);
    assign uart_tx_data  = own_tx ? h_tx_data[{sel_q, 3'b000} +: 8] : data_q;
    assign uart_tx_start = own_tx ? h_tx_start[sel_q] : nak_start_q;
    assign h_activate    = act_q;
    assign busy          = (state_q != S_IDLE);
    assign nak_count     = nak_cnt_q;
    assign timeout_count = tout_cnt_q;

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// tb/tb_uart_cmd_dispatch.sv - randomized bench for uart_cmd_dispatch against a transaction-level model
module tb_uart_cmd_dispatch;

    localparam int N    = 4;
    localparam int BASE = 1;
    localparam int NAK  = 8'h15;
    localparam int T    = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           rx_ready = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           tx_active = 1'b0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   h_done = '0;
    logic [N-1:0]   h_tx_start = '0;
    logic [8*N-1:0] h_tx_data = '0;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_start;
    logic [N-1:0]   h_activate;
    logic           busy;
    logic [7:0]     nak_count;
    logic [7:0]     timeout_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    uart_cmd_dispatch #(
        .N_HANDLERS(N), .OPCODE_BASE(8'(BASE)), .NAK_BYTE(8'(NAK)), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_active(tx_active), .tx_done(tx_done),
        .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .h_activate(h_activate), .h_done(h_done), .h_tx_data(h_tx_data),
        .h_tx_start(h_tx_start), .busy(busy), .nak_count(nak_count),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the TX (-1 = nobody), whether the owner is only draining,
    // how many cycles it has been active, and the NAK sequence position.
    int         m_owner = -1;
    bit         m_rel   = 1'b0;
    int         m_age   = 0;
    int         m_nak   = 0;
    int         m_naks  = 0;
    int         m_touts = 0;
    bit         m_prev  = 1'b1;
    logic [7:0] m_reg   = 8'h00;

    always @(posedge clk) begin
        int o, ag, nk, ns, ts, v;
        bit rl, nb;
        logic [7:0] rg;
        if (!reset) begin
            m_owner <= -1; m_rel <= 1'b0; m_age <= 0; m_nak <= 0;
            m_naks <= 0; m_touts <= 0; m_prev <= 1'b1; m_reg <= 8'h00;
        end else begin
            o = m_owner; rl = m_rel; ag = m_age; nk = m_nak;
            ns = m_naks; ts = m_touts; rg = m_reg;
            nb = rx_ready && !m_prev;
            v  = int'(rx_data) - BASE;
            if (nk == 1) begin
                if (!tx_active) begin nk = 2; rg = 8'(NAK); end
            end else if (nk == 2) begin
                nk = 0;
            end else if (o < 0) begin
                if (nb) begin
                    if (v >= 0 && v < N) begin o = v; rl = 1'b0; ag = 0; end
                    else begin ns = (ns < 255) ? ns + 1 : 255; nk = 1; end
                end
            end else if (!rl) begin
                ag++;
                if (h_done[o]) rl = 1'b1;
                else if (ag == T) begin rl = 1'b1; ts = (ts < 255) ? ts + 1 : 255; end
            end else if (!h_done[o] && !tx_active) begin
                o = -1;
            end
            m_owner <= o; m_rel <= rl; m_age <= ag; m_nak <= nk;
            m_naks <= ns; m_touts <= ts; m_reg <= rg; m_prev <= rx_ready;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_act;
        logic         e_start;
        logic [7:0]   e_data;
        if (chk_en) begin
            e_act   = (m_owner >= 0 && !m_rel) ? (N'(1) << m_owner) : '0;
            e_start = (m_owner >= 0) ? h_tx_start[m_owner] : (m_nak == 2);
            e_data  = (m_owner >= 0) ? h_tx_data[m_owner*8 +: 8] : m_reg;
            chk("model_activate", h_activate, e_act);
            chk("model_tx_start", uart_tx_start, e_start);
            chk("model_tx_data", uart_tx_data, e_data);
            chk("model_busy", busy, (m_owner >= 0) || (m_nak != 0));
            chk("model_nak_count", nak_count, m_naks);
            chk("model_timeout_count", timeout_count, m_touts);
        end
    end

    int n_nak_start = 0;
    bit act_seen = 1'b0;
    always @(negedge clk) begin
        if (chk_en && uart_tx_start && uart_tx_data == 8'h15) n_nak_start++;
        if (chk_en && |h_activate) act_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        tick();
        chk_en = 1'b1;
        chk("rst_activate", h_activate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", uart_tx_start, 0);
        chk("rst_tx_data", uart_tx_data, 0);
        chk("rst_nak_count", nak_count, 0);
        chk("rst_timeout_count", timeout_count, 0);

        // rx level already high when reset releases is not a byte
        rx_data = 8'h02; rx_ready = 1'b1;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("rx_high_at_reset_busy", busy, 0);
        chk("rx_high_at_reset_act", h_activate, 0);
        rx_ready = 1'b0;
        tick();

        // dispatch to handler 2, with noise on handler 0's start strobe
        send_byte(8'h03);
        chk("disp_activate", h_activate, 4'b0100);
        chk("disp_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            h_tx_data[2*8 +: 8] = 8'(i);
            h_tx_data[0 +: 8]   = 8'hEE;
            h_tx_start = 4'b0101;
            #1;
            chk("disp_tx_data", uart_tx_data, i);
            chk("disp_tx_start", uart_tx_start, 1);
            tick();
            h_tx_start = 4'b0001;
            tx_active  = 1'b1;
            #1;
            chk("disp_no_foreign_start", uart_tx_start, 0);
            tick();
            tx_active = 1'b0;
        end
        h_tx_start = '0;
        h_done = 4'b0100;
        tick();
        chk("done_act_drop", h_activate, 0);
        chk("done_busy_release", busy, 1);
        tick();
        chk("done_held_busy", busy, 1);
        h_done = '0;
        tick();
        chk("done_clear_idle", busy, 0);

        // unknown opcodes 0x00 (behind a busy TX) and 0x05
        n_nak_start = 0; act_seen = 1'b0;
        tx_active = 1'b1;
        send_byte(8'h00);
        repeat (3) tick();
        chk("nak_held_by_tx", n_nak_start, 0);
        tx_active = 1'b0;
        tick();
        chk("nak_send_start", uart_tx_start, 1);
        chk("nak_send_data", uart_tx_data, 8'h15);
        tick();
        chk("nak_one_cycle", uart_tx_start, 0);
        send_byte(8'h05);
        repeat (4) tick();
        chk("nak_pulses", n_nak_start, 2);
        chk("nak_count_two", nak_count, 2);
        chk("nak_no_activate", act_seen, 0);

        // single timeout on handler 0
        send_byte(8'h01);
        cnt = 0;
        while (h_activate[0] && cnt < 100) begin tick(); cnt++; end
        chk("timeout_width", cnt, T);
        chk("timeout_count_one", timeout_count, 1);
        tick();
        chk("timeout_idle", busy, 0);

        // done on the final watchdog cycle
        send_byte(8'h02);
        repeat (T - 1) tick();
        h_done = 4'b0010;
        tick();
        chk("collide_act_drop", h_activate, 0);
        chk("collide_no_timeout", timeout_count, 1);
        h_done = '0;
        tick();
        chk("collide_idle", busy, 0);

        // payload byte during ACTIVE and a level held across the return to IDLE
        send_byte(8'h01);
        tick();
        send_byte(8'h01);
        chk("rx_active_act", h_activate, 4'b0001);
        chk("rx_active_nak", nak_count, 2);
        rx_data = 8'h02; rx_ready = 1'b1;
        h_done = 4'b0001;
        tick();
        h_done = '0;
        tick();
        chk("rx_held_idle", busy, 0);
        repeat (3) tick();
        chk("rx_held_no_dispatch", busy, 0);
        chk("rx_held_no_act", h_activate, 0);
        rx_ready = 1'b0;
        tick();

        // drive timeouts until the counter saturates
        for (int i = 1; i < 300; i++) begin
            send_byte(8'(BASE + i % N));
            cnt = 0;
            while (busy && cnt < 60) begin tick(); cnt++; end
            chk("sat_loop_idle", busy, 0);
        end
        chk("timeout_saturated", timeout_count, 255);

        // reset in the middle of a handler transmit
        send_byte(8'h03);
        h_tx_start = 4'b0100; tx_active = 1'b1;
        h_tx_data[2*8 +: 8] = 8'hA5;
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_act", h_activate, 0);
        chk("midrst_start", uart_tx_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_nak", nak_count, 0);
        chk("midrst_tout", timeout_count, 0);
        reset = 1'b1; h_tx_start = '0; tx_active = 1'b0;
        tick();

        // random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) rx_ready = ~rx_ready;
            if (!rx_ready) rx_data = 8'($urandom_range(6));
            tx_active  = ($urandom_range(2) == 0);
            for (int k = 0; k < N; k++) h_done[k] = ($urandom_range(7) == 0);
            h_tx_start = N'($urandom);
            h_tx_data  = $urandom;
            reset      = ($urandom_range(499) != 0);
            tick();
        end
        reset = 1'b1; rx_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
